// File: rtl/sid_i2s_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sid_i2s_tx_pkg : shared types and constants for the SID I2S output stage.  |
// | Rev 1.0  initial release                                                   |
// +----------------------------------------------------------------------------+
package sid_i2s_tx_pkg;

    typedef logic [47:0] audio_t;
    typedef logic [63:0] i2s_frame_t;

    localparam int I2S_SLOT_BITS  = 32;
    localparam int I2S_FRAME_BITS = 64;
    localparam int I2S_DATA_BITS  = 24;
    localparam int I2S_PAD_BITS   = I2S_SLOT_BITS - I2S_DATA_BITS;

    // Left sample in the upper slot, right in the lower, each MSB-aligned with zero pad.
    function automatic i2s_frame_t i2s_frame(input audio_t a);
        return {a[47:24], {I2S_PAD_BITS{1'b0}}, a[23:0], {I2S_PAD_BITS{1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sid_i2s_clkgen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sid_i2s_clkgen : BCLK divider, 6-bit frame bit counter, LRCLK and the      |
// |                  BCLK fall-event strobe.                                   |
// | Rev 1.0  initial release                                                   |
// +----------------------------------------------------------------------------+
module sid_i2s_clkgen #(
    parameter int BCLK_HALF = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       o_bclk,
    output logic       o_lrclk,
    output logic       o_fall,
    output logic [5:0] o_bit_nxt
);

    localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_bclk;
    logic             r_lrclk;
    logic [5:0]       r_bit_cnt;
    logic             w_wrap;
    logic             w_fall;
    logic [5:0]       w_bit_nxt;

    assign w_wrap    = (r_div_cnt == DIV_W'(BCLK_HALF - 1));
    assign w_fall    = w_wrap & r_bclk;
    assign w_bit_nxt = r_bit_cnt + 6'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
            r_lrclk   <= 1'b0;
            r_bit_cnt <= 6'd63;
        end else begin
            r_div_cnt <= w_wrap ? '0 : r_div_cnt + DIV_W'(1);
            if (w_wrap) begin
                r_bclk <= ~r_bclk;
            end
            // Bit counter and word select advance only on the BCLK falling transition.
            if (w_fall) begin
                r_bit_cnt <= w_bit_nxt;
                r_lrclk   <= w_bit_nxt[5];
            end
        end
    end

    assign o_bclk    = r_bclk;
    assign o_lrclk   = r_lrclk;
    assign o_fall    = w_fall;
    assign o_bit_nxt = w_bit_nxt;

endmodule
`default_nettype wire

// File: rtl/sid_i2s_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sid_i2s_tx : captures SID stereo samples and serializes them as a 64-bit   |
// |              I2S frame. Define SID_I2S_LJ_EN for left-justified format.    |
// | Rev 1.0  initial release                                                   |
// +----------------------------------------------------------------------------+
module sid_i2s_tx
    import sid_i2s_tx_pkg::*;
#(
    parameter int BCLK_HALF = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  audio_t audio_i,
    input  logic   audio_stb,
    output logic   i2s_bclk,
    output logic   i2s_lrclk,
    output logic   i2s_sd,
    output logic   frame_o,
    output logic   stale_o
);

`ifdef SID_I2S_LJ_EN
    localparam logic [5:0] c_LOAD_CNT = 6'd0;
`else
    localparam logic [5:0] c_LOAD_CNT = 6'd1;
`endif

    logic       w_fall;
    logic [5:0] w_bit_nxt;
    logic       w_load;
    i2s_frame_t w_word;

    audio_t     r_pending;
    logic       r_fresh;
    i2s_frame_t r_shifter;
    logic       r_sd;
    logic       r_frame;
    logic       r_stale;

    sid_i2s_clkgen #(
        .BCLK_HALF (BCLK_HALF)
    ) u_clkgen (
        .clk       (clk),
        .rst_n     (rst_n),
        .o_bclk    (i2s_bclk),
        .o_lrclk   (i2s_lrclk),
        .o_fall    (w_fall),
        .o_bit_nxt (w_bit_nxt)
    );

    assign w_load = w_fall && (w_bit_nxt == c_LOAD_CNT);
    assign w_word = i2s_frame(r_pending);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_fresh   <= 1'b0;
            r_shifter <= '0;
            r_sd      <= 1'b0;
            r_frame   <= 1'b0;
            r_stale   <= 1'b0;
        end else begin
            if (audio_stb) begin
                r_pending <= audio_i;
            end
            // A strobe landing on the load clock keeps the new sample marked fresh.
            if (audio_stb) begin
                r_fresh <= 1'b1;
            end else if (w_load) begin
                r_fresh <= 1'b0;
            end
            r_frame <= w_load;
            if (w_load) begin
                r_sd      <= w_word[I2S_FRAME_BITS-1];
                r_shifter <= {w_word[I2S_FRAME_BITS-2:0], 1'b0};
                r_stale   <= ~r_fresh;
            end else if (w_fall) begin
                r_sd      <= r_shifter[I2S_FRAME_BITS-1];
                r_shifter <= {r_shifter[I2S_FRAME_BITS-2:0], 1'b0};
            end
        end
    end

    assign i2s_sd  = r_sd;
    assign frame_o = r_frame;
    assign stale_o = r_stale;

endmodule
`default_nettype wire

// File: tb/tb_sid_i2s_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sid_i2s_tx : scoreboard bench for sid_i2s_tx with BCLK_HALF = 2.        |
// | Rev 1.0  initial release                                                   |
// +----------------------------------------------------------------------------+
module tb_sid_i2s_tx;
    import sid_i2s_tx_pkg::*;

    localparam int BH         = 2;
    localparam int FRAME_CLKS = 128 * BH;
`ifdef SID_I2S_LJ_EN
    localparam int          FIRST_LOAD = 4;
    localparam logic [63:0] LR_EXP     = 64'h00000000_FFFFFFFF;
`else
    localparam int          FIRST_LOAD = 8;
    localparam logic [63:0] LR_EXP     = 64'h00000001_FFFFFFFE;
`endif

    typedef struct packed {
        logic [63:0] word;
        logic        stale;
    } exp_t;

    logic   clk;
    logic   rst_n;
    audio_t audio_i;
    logic   audio_stb;
    logic   i2s_bclk, i2s_lrclk, i2s_sd, frame_o, stale_o;

    int     n_cmp  = 0;
    int     n_fail = 0;
    longint cyc    = 0;
    bit     mon_busy = 0;
    exp_t   q[$];

    sid_i2s_tx #(
        .BCLK_HALF (BH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .audio_i   (audio_i),
        .audio_stb (audio_stb),
        .i2s_bclk  (i2s_bclk),
        .i2s_lrclk (i2s_lrclk),
        .i2s_sd    (i2s_sd),
        .frame_o   (frame_o),
        .stale_o   (stale_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [63:0] word, input logic stale);
        exp_t e;
        e.word  = word;
        e.stale = stale;
        q.push_back(e);
    endtask

    task automatic strobe(input audio_t v);
        audio_i   = v;
        audio_stb = 1'b1;
        @(negedge clk);
        audio_stb = 1'b0;
    endtask

    task automatic wait_frame();
        for (int k = 0; k < FRAME_CLKS + 50; k++) begin
            @(negedge clk);
            if (frame_o) return;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL wait_frame: no frame_o within %0d clk", FRAME_CLKS + 50);
    endtask

    task automatic check_release_latency(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_o && n < 40);
        check(name, 64'(n), 64'(FIRST_LOAD));
    endtask

    // Monitor: pops one expectation per frame_o, then gathers 64 bits on BCLK rising edges.
    initial begin
        exp_t        e;
        logic [63:0] w, lr;
        int          idx;
        bit          coll, last_ok;
        logic        pb;
        longint      last;
        coll = 0; last_ok = 0; pb = 1'b0; idx = 0; w = '0; lr = '0; last = 0;
        e = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                coll = 0; mon_busy = 0; pb = 1'b0; last_ok = 0;
                continue;
            end
            if (coll && i2s_bclk && !pb) begin
                w  = {w[62:0], i2s_sd};
                lr = {lr[62:0], i2s_lrclk};
                idx++;
                if (idx == 64) begin
                    check("frame_word", w, e.word);
                    check("lrclk_pattern", lr, LR_EXP);
                    coll = 0;
                    mon_busy = 0;
                end
            end
            pb = i2s_bclk;
            if (frame_o) begin
                if (coll) check("frame_bits", 64'(idx), 64'd64);
                if (last_ok) check("frame_period", 64'(cyc - last), 64'(FRAME_CLKS));
                last = cyc;
                last_ok = 1;
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got frame_o with empty queue, expected none");
                    coll = 0;
                    mon_busy = 0;
                end else begin
                    e = q.pop_front();
                    check("stale", 64'(stale_o), 64'(e.stale));
                    coll = 1; mon_busy = 1; idx = 0; w = '0; lr = '0;
                end
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        n_cmp++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        rst_n     = 1'b0;
        audio_stb = 1'b0;
        audio_i   = '0;
        repeat (3) @(negedge clk);
        check("rst_bclk",  64'(i2s_bclk),  64'd0);
        check("rst_lrclk", 64'(i2s_lrclk), 64'd0);
        check("rst_sd",    64'(i2s_sd),    64'd0);
        check("rst_frame", 64'(frame_o),   64'd0);
        check("rst_stale", 64'(stale_o),   64'd0);

        // F1: nothing captured since reset.
        push_exp(64'h0, 1'b1);
        rst_n = 1'b1;
        check_release_latency("first_load_latency");

        repeat (10) @(negedge clk);
        strobe(48'h800001_7FFFFE);
        push_exp(64'h80000100_7FFFFE00, 1'b0);
        wait_frame();                               // F2

        repeat (20) @(negedge clk);
        strobe(48'h111111_222222);
        repeat (40) @(negedge clk);
        strobe(48'h333333_444444);
        repeat (40) @(negedge clk);
        strobe(48'hC0FFEE_0BADF0);
        push_exp(64'hC0FFEE00_0BADF000, 1'b0);
        wait_frame();                               // F3

        push_exp(64'hC0FFEE00_0BADF000, 1'b1);
        wait_frame();                               // F4
        push_exp(64'hC0FFEE00_0BADF000, 1'b1);
        wait_frame();                               // F5

        // Strobe exactly on the F6 load clock: F6 keeps C, F7 carries D.
        push_exp(64'hC0FFEE00_0BADF000, 1'b1);
        push_exp(64'h5A5A5A00_A5A5A500, 1'b0);
        repeat (FRAME_CLKS - 1) @(posedge clk);
        @(negedge clk);
        audio_i   = 48'h5A5A5A_A5A5A5;
        audio_stb = 1'b1;
        @(negedge clk);
        audio_stb = 1'b0;
        check("stb_on_load_clk", 64'(frame_o), 64'd1);
        wait_frame();                               // F7

        push_exp(64'h5A5A5A00_A5A5A500, 1'b1);
        wait_frame();                               // F8
        repeat (60) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_bclk",  64'(i2s_bclk),  64'd0);
        check("async_rst_lrclk", 64'(i2s_lrclk), 64'd0);
        check("async_rst_sd",    64'(i2s_sd),    64'd0);
        check("async_rst_frame", 64'(frame_o),   64'd0);
        check("async_rst_stale", 64'(stale_o),   64'd0);
        push_exp(64'h0, 1'b1);                      // F9: pending cleared by reset
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_release_latency("post_reset_load_latency");

        repeat (10) @(negedge clk);
        strobe(48'h123456_ABCDEF);
        push_exp(64'h12345600_ABCDEF00, 1'b0);
        wait_frame();                               // F10

        for (int k = 0; k < FRAME_CLKS + 20 && mon_busy; k++) @(negedge clk);
        check("monitor_idle", 64'(mon_busy), 64'd0);
        check("queue_drained", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
